// File: rtl/temp_sample_scheduler.sv
// LM75A sample scheduler: periodic reads, timeout/retry, min/max tracking.
// Optional TEMP_AVG_EN: temp_c becomes a 4-sample moving average.
module temp_sample_scheduler #(
  parameter int SAMPLE_PERIOD  = 12_000_000,
  parameter int TIMEOUT_CYCLES = 60_000,
  parameter int MAX_RETRY      = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        rd_req,
  output logic        rd_abort,
  input  logic        rd_done,
  input  logic        rd_nack,
  input  logic [15:0] rd_data,
  output logic [7:0]  temp_c,
  output logic [7:0]  temp_min,
  output logic [7:0]  temp_max,
  output logic        temp_valid,
  output logic        sample_stb,
  output logic        sensor_found,
  output logic [7:0]  err_cnt,
  output logic        overrun
);

  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_WAIT,
    S_REQ,
    S_BUSY,
    S_EVAL
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [PW-1:0] per_cnt;
  logic [TW-1:0] to_cnt;
  logic [2:0]    retry;
  logic [7:0]    sample;
  logic [7:0]    c_next;
  logic          tick;
  logic          to_last;
  logic          retry_last;
  logic          rd_ok;
  logic          rd_fail;

  assign tick       = (per_cnt == '0);
  assign to_last    = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign retry_last = (({1'b0, retry} + 4'd1) >= 4'(MAX_RETRY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt <= PW'(SAMPLE_PERIOD - 1);
    end else if (tick) begin
      per_cnt <= PW'(SAMPLE_PERIOD - 1);
    end else begin
      per_cnt <= per_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_WAIT;
    else        state <= nxt;
  end

  always_comb begin
    nxt      = state;
    rd_req   = 1'b0;
    rd_abort = 1'b0;
    rd_ok    = 1'b0;
    rd_fail  = 1'b0;
    unique case (state)
      S_WAIT: if (tick) nxt = S_REQ;
      S_REQ: begin
        rd_req = 1'b1;
        nxt    = S_BUSY;
      end
      S_BUSY: begin
        // a completion in the timeout cycle still counts as a completion
        if (rd_done && !rd_nack) begin
          rd_ok = 1'b1;
          nxt   = S_EVAL;
        end else if (rd_done || to_last) begin
          rd_fail  = 1'b1;
          rd_abort = !rd_done;
          nxt      = retry_last ? S_WAIT : S_REQ;
        end
      end
      S_EVAL: nxt = S_WAIT;
      default: nxt = S_WAIT;
    endcase
  end

`ifdef TEMP_AVG_EN
  logic [2:0][7:0]   hist;
  logic [3:0][7:0]   win;
  logic signed [9:0] sum;
  logic              unused_bits;

  always_comb begin
    if (!temp_valid) win = {4{sample}};
    else             win = {hist, sample};
    sum = $signed({{2{win[0][7]}}, win[0]})
        + $signed({{2{win[1][7]}}, win[1]})
        + $signed({{2{win[2][7]}}, win[2]})
        + $signed({{2{win[3][7]}}, win[3]});
    c_next = sum[9:2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              hist <= '0;
    else if (state == S_EVAL) hist <= win[2:0];
  end

  assign unused_bits = ^{rd_data[7:0], sum[1:0], win[3]};
`else
  logic unused_bits;
  assign c_next      = sample;
  assign unused_bits = ^rd_data[7:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt       <= '0;
      retry        <= '0;
      sample       <= '0;
      temp_c       <= '0;
      temp_min     <= '0;
      temp_max     <= '0;
      temp_valid   <= 1'b0;
      sample_stb   <= 1'b0;
      sensor_found <= 1'b0;
      err_cnt      <= '0;
      overrun      <= 1'b0;
    end else begin
      sample_stb <= 1'b0;
      if (tick && state != S_WAIT) overrun <= 1'b1;
      if (state == S_REQ)       to_cnt <= '0;
      else if (state == S_BUSY) to_cnt <= to_cnt + 1'b1;
      if (rd_ok) begin
        sample       <= rd_data[15:8];
        retry        <= '0;
        sensor_found <= 1'b1;
      end
      if (rd_fail) begin
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        if (retry_last) begin
          retry        <= '0;
          sensor_found <= 1'b0;
        end else begin
          retry <= retry + 3'd1;
        end
      end
      if (state == S_EVAL) begin
        temp_c     <= c_next;
        temp_valid <= 1'b1;
        sample_stb <= 1'b1;
        if (!temp_valid || $signed(sample) < $signed(temp_min))
          temp_min <= sample;
        if (!temp_valid || $signed(sample) > $signed(temp_max))
          temp_max <= sample;
      end
    end
  end

endmodule

// File: tb/tb_temp_sample_scheduler.sv
// Directed bench for temp_sample_scheduler.
// Second small instance exercises the overrun path.
module tb_temp_sample_scheduler;

  localparam int SP = 100;
  localparam int TO = 20;
  localparam int MR = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_done = 1'b0;
  logic        rd_nack = 1'b0;
  logic [15:0] rd_data = '0;
  logic        rd_req, rd_abort, temp_valid, sample_stb;
  logic        sensor_found, overrun;
  logic [7:0]  temp_c, temp_min, temp_max, err_cnt;

  logic        o_req, o_abort, o_valid, o_stb, o_found, o_ovr;
  logic [7:0]  o_c, o_min, o_max, o_err;
  logic        o_done = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  temp_sample_scheduler #(
    .SAMPLE_PERIOD(SP), .TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_abort(rd_abort),
    .rd_done(rd_done), .rd_nack(rd_nack), .rd_data(rd_data),
    .temp_c(temp_c), .temp_min(temp_min), .temp_max(temp_max),
    .temp_valid(temp_valid), .sample_stb(sample_stb),
    .sensor_found(sensor_found), .err_cnt(err_cnt),
    .overrun(overrun)
  );

  temp_sample_scheduler #(
    .SAMPLE_PERIOD(20), .TIMEOUT_CYCLES(60), .MAX_RETRY(1)
  ) u_ovr (
    .clk(clk), .rst_n(rst_n),
    .rd_req(o_req), .rd_abort(o_abort),
    .rd_done(o_done), .rd_nack(1'b0), .rd_data(16'h0),
    .temp_c(o_c), .temp_min(o_min), .temp_max(o_max),
    .temp_valid(o_valid), .sample_stb(o_stb),
    .sensor_found(o_found), .err_cnt(o_err),
    .overrun(o_ovr)
  );

  typedef struct {
    int          n_fail;
    int          fail_kind;
    bit          ok;
    int          dly;
    logic [15:0] data;
    logic [7:0]  e_c;
    logic [7:0]  e_avg;
    logic [7:0]  e_min;
    logic [7:0]  e_max;
    logic [7:0]  e_err;
    logic        e_found;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (rd_req === 1'b1) begin
        got = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  // kind 0 = data, 1 = nack, 2 = let it time out
  task automatic attempt(input int kind, input int dly,
                         input logic [15:0] d);
    int n;
    if (kind == 2) begin
      n = 0;
      while (rd_abort !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("abort_latency", 64'(n), 64'(TO));
      @(negedge clk);
    end else begin
      repeat (dly + 1) @(negedge clk);
      rd_done = 1'b1;
      rd_nack = (kind == 1);
      rd_data = d;
      #1;
      chk("no_abort_on_done", 64'(rd_abort), 64'd0);
      @(negedge clk);
      rd_done = 1'b0;
      rd_nack = 1'b0;
      rd_data = '0;
    end
  endtask

  initial begin
    bit         got;
    int         n;
    logic [7:0] exp_c;
    logic [7:0] c_hold;
    logic [7:0] e_hold;

    vecs[0] = '{0, 0, 1'b1, 0,  16'h1980, 8'h19, 8'h19, 8'h19, 8'h19, 8'd0, 1'b1};
    vecs[1] = '{0, 0, 1'b1, 3,  16'hFD00, 8'hFD, 8'h12, 8'hFD, 8'h19, 8'd0, 1'b1};
    vecs[2] = '{0, 0, 1'b1, 1,  16'h1E00, 8'h1E, 8'h13, 8'hFD, 8'h1E, 8'd0, 1'b1};
    vecs[3] = '{3, 1, 1'b0, 0,  16'h0000, 8'h1E, 8'h13, 8'hFD, 8'h1E, 8'd3, 1'b0};
    vecs[4] = '{3, 2, 1'b0, 0,  16'h0000, 8'h1E, 8'h13, 8'hFD, 8'h1E, 8'd6, 1'b0};
    vecs[5] = '{2, 1, 1'b1, 0,  16'h1400, 8'h14, 8'h12, 8'hFD, 8'h1E, 8'd8, 1'b1};
    vecs[6] = '{0, 0, 1'b1, 19, 16'h1500, 8'h15, 8'h11, 8'hFD, 8'h1E, 8'd8, 1'b1};
    vecs[7] = '{0, 0, 1'b1, 2,  16'hF600, 8'hF6, 8'h0F, 8'hF6, 8'h1E, 8'd8, 1'b1};

    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {26'd0, rd_req, rd_abort, temp_c, temp_min, temp_max,
         temp_valid, sample_stb, sensor_found, err_cnt, overrun},
        64'd0);

    rst_n = 1'b1;
    n = 0;
    while (rd_req !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("first_req_cycle", 64'(n), 64'(SP));

    for (int i = 0; i < 8; i++) begin
      wait_req(got);
      chk("tick_req", 64'(got), 64'd1);
      for (int f = 0; f < vecs[i].n_fail; f++) begin
        attempt(vecs[i].fail_kind, 0, 16'h0);
        if (f < vecs[i].n_fail - 1 || vecs[i].ok) begin
          wait_req(got);
          chk("retry_req", 64'(got), 64'd1);
        end
      end
      if (vecs[i].ok) begin
        attempt(0, vecs[i].dly, vecs[i].data);
        chk("stb_early", 64'(sample_stb), 64'd0);
        @(negedge clk);
        chk("stb_n_plus_2", 64'(sample_stb), 64'd1);
      end else begin
        chk("no_extra_req", 64'(rd_req), 64'd0);
      end
`ifdef TEMP_AVG_EN
      exp_c = vecs[i].e_avg;
`else
      exp_c = vecs[i].e_c;
`endif
      chk($sformatf("v%0d_temp_c", i), 64'(temp_c), 64'(exp_c));
      chk($sformatf("v%0d_min", i), 64'(temp_min), 64'(vecs[i].e_min));
      chk($sformatf("v%0d_max", i), 64'(temp_max), 64'(vecs[i].e_max));
      chk($sformatf("v%0d_err", i), 64'(err_cnt), 64'(vecs[i].e_err));
      chk($sformatf("v%0d_found", i), 64'(sensor_found),
          64'(vecs[i].e_found));
      chk($sformatf("v%0d_valid", i), 64'(temp_valid), 64'd1);
    end

    c_hold = temp_c;
    e_hold = err_cnt;
    rd_done = 1'b1;
    rd_data = 16'h7F00;
    @(negedge clk);
    rd_done = 1'b0;
    rd_data = '0;
    repeat (3) @(negedge clk);
    chk("idle_done_temp", 64'(temp_c), 64'(c_hold));
    chk("idle_done_err", 64'(err_cnt), 64'(e_hold));
    chk("idle_done_stb", 64'(sample_stb), 64'd0);

    chk("main_overrun", 64'(overrun), 64'd0);
    chk("stall_overrun", 64'(o_ovr), 64'd1);

    wait_req(got);
    chk("pre_reset_req", 64'(got), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_busy",
        {26'd0, rd_req, rd_abort, temp_c, temp_min, temp_max,
         temp_valid, sample_stb, sensor_found, err_cnt, overrun},
        64'd0);
    chk("reset_mid_busy_ovr", 64'(o_ovr), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
